// File: rtl/test_mac_unit.sv
`default_nettype none
// ============================================================================
// Module      : test_mac_unit (with test_mac_unit_ctrl, test_mac_unit_dp)
// Description : Systolic-array processing element. Operands are forwarded
//               east/south with one cycle of delay while a multiply-accumulate
//               datapath sums ACC_LEN products into each published result.
//               A small controller (IDLE/RUN FSM plus modulo-ACC_LEN counter)
//               decides which cycle closes a result.
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Load controller: one IDLE cycle after reset release, then RUN forever.
// o_load marks the cycle whose product completes a result.
// ----------------------------------------------------------------------------
module test_mac_unit_ctrl #(
  parameter int ACC_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  output logic o_run,
  output logic o_load
);

  // 8 bits covers the full legal ACC_LEN range of 1..255.
  localparam int          CNT_W  = 8;
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(ACC_LEN - 1);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_RUN  = 1'b1;

  logic [0:0]       r_state;
  logic [CNT_W-1:0] w_cnt;

  // State register: IDLE absorbs the reset-release edge, RUN is terminal.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_IDLE;
    end else if (r_state == c_IDLE) begin
      r_state <= c_RUN;
    end
  end

  generate
    if (ACC_LEN == 1) begin : g_cnt_single
      // Every RUN cycle closes a result, so no counter is needed.
      assign w_cnt = '0;
    end else begin : g_cnt_multi
      logic [CNT_W-1:0] r_cnt;

      // Product-position counter: advances only in RUN, wraps at ACC_LEN-1.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_cnt <= '0;
        end else if (r_state == c_RUN) begin
          if (r_cnt == c_LAST) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      end

      assign w_cnt = r_cnt;
    end
  endgenerate

  // Decoded purely from registers so load has no combinational input path.
  assign o_run  = (r_state == c_RUN);
  assign o_load = (r_state == c_RUN) && (w_cnt == c_LAST);

endmodule

// ----------------------------------------------------------------------------
// MAC datapath: operand forwarding plus wrap-around accumulate.
// ----------------------------------------------------------------------------
module test_mac_unit_dp #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_run,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_a,
  output logic [DATA_WIDTH-1:0] o_b,
  output logic [DATA_WIDTH-1:0] o_c
);

  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_c;
  logic [DATA_WIDTH-1:0] w_prod;
  logic [DATA_WIDTH-1:0] w_sum;

  // Same-width product keeps only the low DATA_WIDTH bits; sums wrap freely.
  assign w_prod = i_a * i_b;
  assign w_sum  = r_acc + w_prod;

  // Neighbour forwarding registers, independent of the controller.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a <= '0;
      r_b <= '0;
    end else begin
      r_a <= i_a;
      r_b <= i_b;
    end
  end

  // Accumulate in RUN; on the load cycle publish the sum and restart from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
      r_c   <= '0;
    end else if (i_run) begin
      if (i_load) begin
        r_c   <= w_sum;
        r_acc <= '0;
      end else begin
        r_acc <= w_sum;
      end
    end
  end

  assign o_a = r_a;
  assign o_b = r_b;
  assign o_c = r_c;

endmodule

// ----------------------------------------------------------------------------
// Top level: controller feeding the datapath.
// ----------------------------------------------------------------------------
module test_mac_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_LEN    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] A_in,
  input  logic [DATA_WIDTH-1:0] B_in,
  output logic [DATA_WIDTH-1:0] A_out,
  output logic [DATA_WIDTH-1:0] B_out,
  output logic [DATA_WIDTH-1:0] C_out,
  output logic                  load
);

  logic w_run;
  logic w_load;

  test_mac_unit_ctrl #(
    .ACC_LEN (ACC_LEN)
  ) u_ctrl (
    .clk    (clk),
    .rst    (rst),
    .o_run  (w_run),
    .o_load (w_load)
  );

  test_mac_unit_dp #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_dp (
    .clk    (clk),
    .rst    (rst),
    .i_run  (w_run),
    .i_load (w_load),
    .i_a    (A_in),
    .i_b    (B_in),
    .o_a    (A_out),
    .o_b    (B_out),
    .o_c    (C_out)
  );

  assign load = w_load;

endmodule

`default_nettype wire

// File: tb/tb_test_mac_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_test_mac_unit
// Description : Self-checking bench for test_mac_unit. Drives a default
//               instance (ACC_LEN=3) and an ACC_LEN=1 instance from the same
//               operand stream; expected results come from a vector table
//               and a result queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_test_mac_unit;

  logic        clk;
  logic        rst;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] a_out, b_out, c_out;
  logic        load;
  logic [31:0] a_out1, b_out1, c_out1;
  logic        load1;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ld;
    logic [31:0] res;
  } vec_t;

  vec_t        tbl [19];
  logic [31:0] sb [$];
  logic [31:0] held;
  logic [31:0] prod1;

  test_mac_unit #(.DATA_WIDTH(32), .ACC_LEN(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .A_in  (a_in),
    .B_in  (b_in),
    .A_out (a_out),
    .B_out (b_out),
    .C_out (c_out),
    .load  (load)
  );

  test_mac_unit #(.DATA_WIDTH(32), .ACC_LEN(1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .A_in  (a_in),
    .B_in  (b_in),
    .A_out (a_out1),
    .B_out (b_out1),
    .C_out (c_out1),
    .load  (load1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a_out"},  a_out,  32'd0);
    check({tag, "_b_out"},  b_out,  32'd0);
    check({tag, "_c_out"},  c_out,  32'd0);
    check({tag, "_load"},   {31'd0, load}, 32'd0);
    check({tag, "_c_out1"}, c_out1, 32'd0);
    check({tag, "_load1"},  {31'd0, load1}, 32'd0);
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] b);
    a_in = a;
    b_in = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Row i holds the operands present at the i-th edge after reset release;
    // ld is the load value expected before that edge, res the result it closes.
    tbl[0]  = '{32'd7,        32'd7, 1'b0, 32'd0};      // IDLE edge, ignored
    tbl[1]  = '{32'd2,        32'd3, 1'b0, 32'd0};
    tbl[2]  = '{32'd2,        32'd3, 1'b0, 32'd0};
    tbl[3]  = '{32'd2,        32'd3, 1'b1, 32'd18};
    tbl[4]  = '{32'd2,        32'd3, 1'b0, 32'd0};
    tbl[5]  = '{32'd2,        32'd3, 1'b0, 32'd0};
    tbl[6]  = '{32'd2,        32'd3, 1'b1, 32'd18};
    tbl[7]  = '{32'd1,        32'd4, 1'b0, 32'd0};
    tbl[8]  = '{32'd2,        32'd5, 1'b0, 32'd0};
    tbl[9]  = '{32'd3,        32'd6, 1'b1, 32'd32};
    tbl[10] = '{32'd0,        32'd9, 1'b0, 32'd0};
    tbl[11] = '{32'd0,        32'd9, 1'b0, 32'd0};
    tbl[12] = '{32'd0,        32'd9, 1'b1, 32'd0};
    tbl[13] = '{32'h0000FFFF, 32'h0000FFFF, 1'b0, 32'd0};
    tbl[14] = '{32'h0000FFFF, 32'h0000FFFF, 1'b0, 32'd0};
    tbl[15] = '{32'h0000FFFF, 32'h0000FFFF, 1'b1, 32'hFFFA0003};
    tbl[16] = '{32'hA5A5A5A5, 32'd1, 1'b0, 32'd0};
    tbl[17] = '{32'h5A5A5A5A, 32'd2, 1'b0, 32'd0};
    tbl[18] = '{32'd0,        32'd0, 1'b1, 32'h5A5A5A59};

    // Reset held: random operands and running clock must leave outputs at 0.
    rst  = 1'b0;
    a_in = '0;
    b_in = '0;
    #1;
    check_all_zero("rst_t0");
    for (int i = 0; i < 4; i++) begin
      step($urandom, $urandom);
      check_all_zero("rst_hold");
    end

    // Release between edges; the next edge is the IDLE->RUN edge.
    rst  = 1'b1;
    held = 32'd0;
    for (int i = 0; i < 19; i++) begin
      check("load", {31'd0, load}, {31'd0, tbl[i].ld});
      check("load_acc1", {31'd0, load1}, (i == 0) ? 32'd0 : 32'd1);
      if (tbl[i].ld) sb.push_back(tbl[i].res);
      step(tbl[i].a, tbl[i].b);
      check("a_out", a_out, tbl[i].a);
      check("b_out", b_out, tbl[i].b);
      check("a_out_acc1", a_out1, tbl[i].a);
      if (tbl[i].ld) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL scoreboard: queue empty at row %0d", i);
        end else begin
          held = sb.pop_front();
        end
      end
      check("c_out", c_out, held);
      prod1 = tbl[i].a * tbl[i].b;
      check("c_out_acc1", c_out1, (i == 0) ? 32'd0 : prod1);
    end

    // Mid-run reset: two products of 5*5 accumulated, then reset between edges.
    step(32'd5, 32'd5);
    step(32'd5, 32'd5);
    check("pre_rst_load", {31'd0, load}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    step(32'd5, 32'd5);
    check_all_zero("async_rst_hold");
    rst = 1'b1;

    // IDLE edge with 5*5 present must not contribute.
    check("post_rst_idle_load", {31'd0, load}, 32'd0);
    step(32'd5, 32'd5);
    check("post_rst_idle_c", c_out, 32'd0);
    sb.push_back(32'd3);
    for (int i = 0; i < 3; i++) begin
      check("post_rst_load", {31'd0, load}, (i == 2) ? 32'd1 : 32'd0);
      step(32'd1, 32'd1);
      check("post_rst_c_out1", c_out1, 32'd1);
    end
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard: queue empty after mid-run reset");
    end else begin
      held = sb.pop_front();
    end
    check("post_rst_c_out", c_out, held);
    step(32'd9, 32'd9);
    check("post_rst_c_hold", c_out, held);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/test_mac_unit.md
TEST_MAC_UNIT -- requirements
Module: test_mac_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of operands, pass-through buses and result.
REQ-002 Parameter ACC_LEN, default 3, number of products summed per result (legal range 1..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 A_in  input  DATA_WIDTH  row operand from west neighbour or array edge.
REQ-006 B_in  input  DATA_WIDTH  column operand from north neighbour or array edge.
REQ-007 A_out  output  DATA_WIDTH  A_in delayed one cycle, to east neighbour.
REQ-008 B_out  output  DATA_WIDTH  B_in delayed one cycle, to south neighbour.
REQ-009 C_out  output  DATA_WIDTH  last completed dot-product result.
REQ-010 load  output  1  high for the one cycle in which the final product of a result is accumulated.

Function
REQ-011 Block SHALL contain two parts: a load controller (counter plus FSM) and a MAC datapath consuming the controller's load.
REQ-012 A_out SHALL equal A_in registered one cycle, and B_out SHALL equal B_in registered one cycle, regardless of load.
REQ-013 Product SHALL be unsigned A_in*B_in truncated to DATA_WIDTH bits; accumulation SHALL be modulo 2^DATA_WIDTH with no saturation or overflow flag.
REQ-014 Controller FSM SHALL have states IDLE and RUN; reset enters IDLE; IDLE SHALL go to RUN on the first rising edge after reset release; RUN SHALL persist until reset.
REQ-015 In IDLE, no product SHALL be accumulated, load SHALL be 0, and cnt SHALL stay 0.
REQ-016 In RUN, an internal counter cnt (0..ACC_LEN-1) SHALL increment each cycle and wrap from ACC_LEN-1 to 0.
REQ-017 load SHALL be 1 exactly when state is RUN and cnt == ACC_LEN-1, decoded from registered state only (no input path).
REQ-018 In RUN with load=0, each edge SHALL update acc <= acc + A_in*B_in, leaving C_out unchanged.
REQ-019 In RUN with load=1, each edge SHALL update C_out <= acc + A_in*B_in and acc <= 0.
REQ-020 With ACC_LEN=1, load SHALL be 1 every RUN cycle and C_out SHALL equal the previous cycle's product.
REQ-021 Latency: result containing products from RUN cycles k..k+ACC_LEN-1 SHALL appear on C_out one edge after cycle k+ACC_LEN-1 and hold for ACC_LEN cycles.

Reset
REQ-022 While rst=0, state=IDLE, cnt=0, acc=0, A_out=0, B_out=0, C_out=0, load=0, applied immediately without waiting for clk.
REQ-023 Reset asserted mid-accumulation SHALL discard the partial sum; after release the first result SHALL include only post-reset RUN-cycle products.
REQ-024 Reset release SHALL be synchronised by the IDLE cycle, so the first accumulated product is the one present on the second edge after release.

Verification
REQ-025 Reset: drive rst=0 with random A_in/B_in and toggling clk -> all outputs 0 throughout; assert rst=0 between edges -> outputs 0 before next edge.
REQ-026 Constant operands, ACC_LEN=3: A_in=2, B_in=3 from release -> load pattern 0 (IDLE),0,0,1 repeating every 3 cycles; C_out=18 after first load edge, then stays 18.
REQ-027 Sequence, ACC_LEN=3: RUN-cycle A_in=1,2,3 and B_in=4,5,6 -> C_out=32 after load edge; next group A=0,0,0 -> C_out=0.
REQ-028 Overflow, DATA_WIDTH=32: A_in=B_in=0x0000FFFF for 3 RUN cycles -> C_out=0xFFFA0003.
REQ-029 Pass-through: A_in=0xA5A5A5A5 then 0x5A5A5A5A on successive edges -> A_out follows one cycle later; B_out likewise, independent of load.
REQ-030 Mid-run reset: assert rst after 2 of 3 products (A=B=5), release, apply A=B=1 -> first C_out=3, not 53.
